// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: shares a bank of NUM_SBOX AES sboxes between the round
// datapath (128-bit SubBytes) and key expansion (32-bit SubWord).
// Each op is processed NUM_SBOX bytes per cycle, in place, in a work register.
// Build option: define ARB_RR_EN for round-robin arbitration of simultaneous
// requests; otherwise fixed priority with the key word always winning.

// Single AES sbox: GF(2^8) multiplicative inverse followed by the affine map.
module sub_bytes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the inverse of a (and maps 0 to 0): product of a^2 .. a^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign o_byte = affine(gf_inv(i_byte));
endmodule

module sub_bytes_sched #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req,
    input  logic [127:0] st_in,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_req,
    input  logic [31:0]  kw_in,
    output logic         kw_ack,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);
    localparam int NS     = 16 / NUM_SBOX;
    localparam int NK     = 4 / NUM_SBOX;
    localparam int BANK_W = 8 * NUM_SBOX;
    localparam logic [3:0] ST_LAST = 4'(NS - 1);
    localparam logic [3:0] KW_LAST = 4'(NK - 1);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
        $error("sub_bytes_sched: NUM_SBOX must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, KEY, STATE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [127:0]        r_work;
    logic [127:0]        w_work_next;
    logic [3:0]          r_cnt;
    logic [6:0]          w_base;
    logic [BANK_W-1:0]   w_bank_in;
    logic [BANK_W-1:0]   w_bank_out;
    logic                w_pick_kw;
    logic                w_pick_st;
    logic                w_take_kw;
    logic                w_take_st;
    logic                w_last;
    logic                r_st_ack;
    logic                r_st_done;
    logic [127:0]        r_st_out;
    logic                r_kw_ack;
    logic                r_kw_done;
    logic [31:0]         r_kw_out;

    // Arbitration between the two requesters (only acted on in IDLE).
`ifdef ARB_RR_EN
    logic r_pri_kw;  // 1: key wins the next tie (key wins the first tie after reset)
    assign w_pick_kw = kw_req & (~st_req | r_pri_kw);
`else
    assign w_pick_kw = kw_req;
`endif
    assign w_pick_st = st_req & ~w_pick_kw;

    // Current slice of the work register through the sbox bank.
    assign w_base    = 7'(r_cnt * BANK_W);
    assign w_bank_in = r_work[w_base +: BANK_W];

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_bank
        sub_bytes_sbox u_sbox (
            .i_byte (w_bank_in[8*g +: 8]),
            .o_byte (w_bank_out[8*g +: 8])
        );
    end

    // Write the substituted slice back in place.
    always_comb begin
        w_work_next = r_work;
        w_work_next[w_base +: BANK_W] = w_bank_out;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: grant in IDLE, finish on the last slice.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_next = r_state;
        w_take_kw    = 1'b0;
        w_take_st    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_kw) begin
                    w_take_kw    = 1'b1;
                    w_state_next = KEY;
                end else if (w_pick_st) begin
                    w_take_st    = 1'b1;
                    w_state_next = STATE;
                end
            end
            KEY: begin
                if (r_cnt == KW_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            STATE: begin
                if (r_cnt == ST_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Work register, slice counter, handshake pulses and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_st_ack  <= 1'b0;
            r_st_done <= 1'b0;
            r_st_out  <= '0;
            r_kw_ack  <= 1'b0;
            r_kw_done <= 1'b0;
            r_kw_out  <= '0;
`ifdef ARB_RR_EN
            r_pri_kw  <= 1'b1;
`endif
        end else begin
            r_st_ack  <= w_take_st;
            r_kw_ack  <= w_take_kw;
            r_st_done <= w_last && (r_state == STATE);
            r_kw_done <= w_last && (r_state == KEY);
            if (w_take_kw) begin
                r_work <= {96'b0, kw_in};
                r_cnt  <= '0;
            end else if (w_take_st) begin
                r_work <= st_in;
                r_cnt  <= '0;
            end else if (r_state != IDLE) begin
                r_work <= w_work_next;
                r_cnt  <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (w_last && (r_state == STATE)) r_st_out <= w_work_next;
                if (w_last && (r_state == KEY))   r_kw_out <= w_work_next[31:0];
            end
`ifdef ARB_RR_EN
            if (w_take_kw)      r_pri_kw <= 1'b0;
            else if (w_take_st) r_pri_kw <= 1'b1;
`endif
        end
    end

    assign st_ack  = r_st_ack;
    assign st_done = r_st_done;
    assign st_out  = r_st_out;
    assign kw_ack  = r_kw_ack;
    assign kw_done = r_kw_done;
    assign kw_out  = r_kw_out;
    assign busy    = (r_state != IDLE);
endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched: self-checking bench for sub_bytes_sched (NUM_SBOX=4).
// Reference sbox table is generated with the multiply-by-3 / divide-by-3
// walk over GF(2^8); results are compared against it and known vectors.
module tb_sub_bytes_sched;
    localparam int NUM_SBOX = 4;
    localparam int NS       = 16 / NUM_SBOX;
    localparam int NK       = 4 / NUM_SBOX;
    localparam int BUDGET   = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_req;
    logic [127:0] st_in;
    logic         st_ack;
    logic         st_done;
    logic [127:0] st_out;
    logic         kw_req;
    logic [31:0]  kw_in;
    logic         kw_ack;
    logic         kw_done;
    logic [31:0]  kw_out;
    logic         busy;

    always #5 clk = ~clk;

    sub_bytes_sched #(.NUM_SBOX(NUM_SBOX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .st_req  (st_req),
        .st_in   (st_in),
        .st_ack  (st_ack),
        .st_done (st_done),
        .st_out  (st_out),
        .kw_req  (kw_req),
        .kw_in   (kw_in),
        .kw_ack  (kw_ack),
        .kw_done (kw_done),
        .kw_out  (kw_out),
        .busy    (busy)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_st;  // value st_out must hold
    logic [127:0] exp_kw;  // value kw_out must hold

    typedef struct {
        logic         is_key;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] x, input int nbytes);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < nbytes; i++) y[8*i +: 8] = sbox_tab[x[8*i +: 8]];
        return y;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_st_ack"},  st_ack,  0);
        check({name, "_st_done"}, st_done, 0);
        check({name, "_st_out"},  st_out,  0);
        check({name, "_kw_ack"},  kw_ack,  0);
        check({name, "_kw_done"}, kw_done, 0);
        check({name, "_kw_out"},  kw_out,  0);
        check({name, "_busy"},    busy,    0);
    endtask

    // One full handshake: request, ack, done; checks result, latency and held outputs.
    task automatic run_op(input string name, input logic is_key,
                          input logic [127:0] din, input logic [127:0] dexp);
        int   n;
        logic seen;
        @(negedge clk);
        if (is_key) begin kw_req = 1'b1; kw_in = din[31:0]; end
        else        begin st_req = 1'b1; st_in = din;       end
        n = 0; seen = 1'b0;
        while (!seen && n < BUDGET) begin
            @(posedge clk); #1; n++;
            seen = is_key ? kw_ack : st_ack;
        end
        check({name, "_ack"}, seen, 1);
        kw_req = 1'b0;
        st_req = 1'b0;
        if (!seen) return;
        kw_in = $urandom;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        check({name, "_busy"}, busy, 1);
        n = 0; seen = 1'b0;
        while (!seen && n < BUDGET) begin
            @(posedge clk); #1; n++;
            seen = is_key ? kw_done : st_done;
        end
        check({name, "_done"}, seen, 1);
        check({name, "_latency"}, n, is_key ? NK : NS);
        check({name, "_idle"}, busy, 0);
        if (is_key) begin
            check({name, "_kw_out"}, {96'b0, kw_out}, dexp);
            check({name, "_st_held"}, st_out, exp_st);
            exp_kw = dexp;
        end else begin
            check({name, "_st_out"}, st_out, dexp);
            check({name, "_kw_held"}, {96'b0, kw_out}, exp_kw);
            exp_st = dexp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           dones;
        int           dbl;
        int           kw_acks;
        int           st_acks;
        int           st_first;
        int           spur;
        logic         seen;
        logic [3:0]   seq;
        logic [31:0]  kd;
        logic [127:0] sd;
        logic         k;

        vecs[0] = '{1'b0, 128'h0, {16{8'h63}}};
        vecs[1] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                    128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[2] = '{1'b1, 128'h04030201, 128'hf27b777c};
        vecs[3] = '{1'b0, {16{8'hff}}, {16{8'h16}}};

        build_sbox();
        exp_st = '0;
        exp_kw = '0;
        rst_n  = 1'b0;
        st_req = 1'b0;
        kw_req = 1'b0;
        st_in  = '0;
        kw_in  = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Known vectors.
        for (int i = 0; i < 4; i++)
            run_op($sformatf("vec%0d", i), vecs[i].is_key, vecs[i].din, vecs[i].dexp);

        // Reset two cycles into a state op: op discarded, no done afterwards.
        @(negedge clk);
        st_req = 1'b1;
        st_in  = {$urandom, $urandom, $urandom, $urandom};
        n = 0; seen = 1'b0;
        while (!seen && n < BUDGET) begin @(posedge clk); #1; n++; seen = st_ack; end
        check("midrst_ack", seen, 1);
        st_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_pre_done", st_done, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_st = '0;
        exp_kw = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (NS + 4) begin @(posedge clk); #1; if (st_done) spur++; end
        check("midrst_no_done", spur, 0);
        run_op("midrst_rereq", 1'b0, {16{8'h53}}, {16{8'hed}});

        // Simultaneous requests, two rounds.
        seq = '0; dbl = 0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            kd = $urandom;
            sd = {$urandom, $urandom, $urandom, $urandom};
            kw_req = 1'b1; kw_in = kd;
            st_req = 1'b1; st_in = sd;
            dones = 0; n = 0;
            while (dones < 2 && n < BUDGET) begin
                @(posedge clk); #1; n++;
                if (kw_ack && st_ack) dbl++;
                if (kw_ack) begin seq = {seq[2:0], 1'b1}; kw_req = 1'b0; end
                if (st_ack) begin seq = {seq[2:0], 1'b0}; st_req = 1'b0; end
                if (kw_done) dones++;
                if (st_done) dones++;
            end
            kw_req = 1'b0;
            st_req = 1'b0;
            check($sformatf("tie%0d_dones", r), dones, 2);
            exp_kw = ref_sub({96'b0, kd}, 4);
            exp_st = ref_sub(sd, 16);
            check($sformatf("tie%0d_kw_out", r), {96'b0, kw_out}, exp_kw);
            check($sformatf("tie%0d_st_out", r), st_out, exp_st);
        end
        check("tie_order", seq, 4'b1010);
        check("tie_double_grant", dbl, 0);

        // kw_req held high continuously while st_req waits.
        @(negedge clk);
        kd = 32'h0c0d0e0f;
        sd = {$urandom, $urandom, $urandom, $urandom};
        kw_req = 1'b1; kw_in = kd;
        st_req = 1'b1; st_in = sd;
        kw_acks = 0; st_acks = 0; st_first = -1; seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (kw_ack) kw_acks++;
            if (st_ack) begin st_acks++; if (st_first < 0) st_first = c; st_req = 1'b0; end
            if (st_done) seen = 1'b1;
        end
`ifdef ARB_RR_EN
        check("rr_st_ack_bound", (st_first > 0) && (st_first <= NK + 2), 1);
`else
        check("fp_st_starved", st_acks, 0);
        check("fp_kw_acks", kw_acks, 40 / (NK + 1));
`endif
        @(negedge clk);
        kw_req = 1'b0;
        n = 0;
        while (!seen && n < BUDGET) begin
            @(posedge clk); #1; n++;
            if (st_ack) st_req = 1'b0;
            if (st_done) seen = 1'b1;
        end
        st_req = 1'b0;
        check("hold_st_done", seen, 1);
        n = 0;
        while (busy && n < BUDGET) begin @(posedge clk); #1; n++; end
        check("hold_idle", busy, 0);
        exp_kw = ref_sub({96'b0, kd}, 4);
        exp_st = ref_sub(sd, 16);
        check("hold_kw_out", {96'b0, kw_out}, exp_kw);
        check("hold_st_out", st_out, exp_st);

        // Randomized ops against the table model, with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            k = 1'($urandom_range(0, 1));
            if (k) sd = {96'b0, 32'($urandom)};
            else   sd = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rand%0d", i), k, sd, ref_sub(sd, k ? 4 : 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
